alu_regfile_mp: RTL

Parametrised multi-ported register file for the ALU cluster, with registered read addresses, same-cycle write-to-read bypass, deterministic multi-port write priority and a per-entry pending scoreboard. It sits between the issue stage and the ALU, shift and load result buses. It supplies operand data plus a ready flag per read port, and replaces the fixed 6-read/5-write ALU register file.

---
 rtl/alu_regfile_mp.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_regfile_mp.sv
// rtl/alu_regfile_mp.sv - multi-ported ALU register file with write bypass and pending scoreboard
//
// Purpose: DEPTH x WIDTH register file feeding the ALU cluster. Read addresses
// are registered (held on stall). Read data is bypassed from same-cycle writes,
// and the highest write port wins. A per-entry pending bit tracks in-flight producers.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   stall           holds read address registers, blocks issue marking
//   rd_addr/rd_data/rd_ready   NRD read ports (data and operand-ready)
//   wr_addr/wr_data/wr_wen     NWR write ports (result buses)
//   iss_addr/iss_en            NISS issue ports marking entries pending
//   pend_cnt        registered count of pending entries
//   err_wr_oob      registered pulse on out-of-range write or issue
module alu_regfile_mp #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 20,
    parameter int AW    = 5,
    parameter int NRD   = 6,
    parameter int NWR   = 5,
    parameter int NISS  = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_ready,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    input  logic [NWR-1:0]       wr_wen,
    input  logic [NISS*AW-1:0]   iss_addr,
    input  logic [NISS-1:0]      iss_en,
    output logic [CW-1:0]        pend_cnt,
    output logic                 err_wr_oob
);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pend_nxt;
    logic [AW-1:0]    addr_q [NRD];
    logic [CW-1:0]    cnt_nxt;
    logic             oob_nxt;
    logic [NRD-1:0]   byp_hit;
    logic [WIDTH-1:0] byp_data [NRD];

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Bypass search: scanning ports upward lets the highest matching port win,
    // which is the same port whose write lands in storage.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            byp_hit[i]  = 1'b0;
            byp_data[i] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_wen[j] && wr_addr[j*AW +: AW] == addr_q[i]) begin
                    byp_hit[i]  = 1'b1;
                    byp_data[i] = wr_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Outputs are forced to their reset values while rst is low, so live write
    // inputs cannot leak through the bypass during reset.
    always_comb begin
        rd_data  = '0;
        rd_ready = '1;
        if (rst) begin
            for (int i = 0; i < NRD; i++) begin
                if (!in_range(addr_q[i])) begin
                    rd_data[i*WIDTH +: WIDTH] = '0;
                    rd_ready[i]               = 1'b0;
                end else begin
                    rd_data[i*WIDTH +: WIDTH] = byp_hit[i] ? byp_data[i] : ram[addr_q[i]];
                    rd_ready[i]               = !pending[addr_q[i]] || byp_hit[i];
                end
            end
        end
    end

    // Next pending state: clears first, then sets, so a new producer issued in
    // the same cycle as a retiring write keeps the entry pending.
    always_comb begin
        pend_nxt = pending;
        oob_nxt  = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_wen[j]) begin
                if (in_range(wr_addr[j*AW +: AW]))
                    pend_nxt[wr_addr[j*AW +: AW]] = 1'b0;
                else
                    oob_nxt = 1'b1;
            end
        end
        if (!stall) begin
            for (int k = 0; k < NISS; k++) begin
                if (iss_en[k]) begin
                    if (in_range(iss_addr[k*AW +: AW]))
                        pend_nxt[iss_addr[k*AW +: AW]] = 1'b1;
                    else
                        oob_nxt = 1'b1;
                end
            end
        end
        cnt_nxt = '0;
        for (int e = 0; e < DEPTH; e++)
            cnt_nxt = cnt_nxt + CW'(pend_nxt[e]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++)
                ram[e] <= '0;
            for (int i = 0; i < NRD; i++)
                addr_q[i] <= '0;
            pending    <= '0;
            pend_cnt   <= '0;
            err_wr_oob <= 1'b0;
        end else begin
            // Later ports override earlier ones on a shared address.
            for (int j = 0; j < NWR; j++) begin
                if (wr_wen[j] && in_range(wr_addr[j*AW +: AW]))
                    ram[wr_addr[j*AW +: AW]] <= wr_data[j*WIDTH +: WIDTH];
            end
            if (!stall) begin
                for (int i = 0; i < NRD; i++)
                    addr_q[i] <= rd_addr[i*AW +: AW];
            end
            pending    <= pend_nxt;
            pend_cnt   <= cnt_nxt;
            err_wr_oob <= oob_nxt;
        end
    end

endmodule
